// File: rtl/adda_pkg.sv
// Shared register map, bit positions and default sizing for the ADC averaging buffer.
// Pure declarations: no latency or backpressure of its own.
package adda_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_DATA    = 3'd2;
    localparam logic [2:0] ADDR_THRESH  = 3'd3;
    localparam logic [2:0] ADDR_LATEST0 = 3'd4;
    localparam logic [2:0] ADDR_LATEST1 = 3'd5;
    localparam logic [2:0] ADDR_LATEST2 = 3'd6;
    localparam logic [2:0] ADDR_LATEST3 = 3'd7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_LEVEL_LSB = 4;

    localparam int DATA_VALID = 31;

    localparam int DEF_AVG_SHIFT = 3;
    localparam int DEF_FIFO_AW   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level/full/empty and synchronous flush; head is combinational (0-cycle read).
// Push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
    parameter int W  = 10,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [W-1:0] mem_q [2**AW];
    logic         do_push;
    logic         do_pop;

    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o    = wr_q - rd_q;
    assign head_dat_o = mem_q[rd_q[AW-1:0]];

    // When full, a same-cycle pop frees the slot the push overwrites; the head is read before the edge.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/adc_avg_buf.sv
// Per-channel ADC sample averager feeding a result FIFO behind an Avalon-MM slave; result pushed 1 cycle after the final sample, readdata latency 1.
// No input backpressure: results arriving at a full FIFO are dropped and flagged in STATUS.ovf.
module adc_avg_buf
    import adda_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int AVG_SHIFT = DEF_AVG_SHIFT,
    parameter int FIFO_AW   = DEF_FIFO_AW
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic [1:0]        smp_ch,
    input  logic [2:0]        avl_address,
    input  logic              avl_write,
    input  logic [31:0]       avl_writedata,
    input  logic              avl_read,
    output logic [31:0]       avl_readdata,
    output logic              irq
);

    localparam int ACC_W = DATA_W + AVG_SHIFT;
    localparam int ENT_W = DATA_W + 2;

    logic [1:0]           ctrl_q, ctrl_d;
    logic [FIFO_AW:0]     thresh_q, thresh_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_W-1:0]     acc_q [4];
    logic [ACC_W-1:0]     acc_d [4];
    logic [AVG_SHIFT-1:0] cnt_q [4];
    logic [AVG_SHIFT-1:0] cnt_d [4];
    logic [DATA_W-1:0]    latest_q [4];
    logic [DATA_W-1:0]    latest_d [4];
    logic                 push_vld_q, push_vld_d;
    logic [ENT_W-1:0]     push_dat_q, push_dat_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_q, irq_d;

    logic                 wr_ctrl;
    logic                 wr_thresh;
    logic                 clr;
    logic                 pop;
    logic                 fifo_push;
    logic                 take;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AW:0]     fifo_level;
    logic [ENT_W-1:0]     fifo_head;
    logic [ACC_W-1:0]     sum;
    logic [31:0]          rd_mux;
    logic                 unused_bits;

    assign wr_ctrl   = avl_write && (avl_address == ADDR_CTRL);
    assign wr_thresh = avl_write && (avl_address == ADDR_THRESH);
    assign clr       = wr_ctrl && avl_writedata[CTRL_CLR];
    assign pop       = avl_read && (avl_address == ADDR_DATA) && !fifo_empty && !clr;
    assign fifo_push = push_vld_q && !clr;
    assign take      = smp_valid && ctrl_q[CTRL_EN] && !clr;
    assign sum       = acc_q[smp_ch] + ACC_W'(smp_data);

    assign unused_bits = ^{avl_writedata, sum[AVG_SHIFT-1:0]};

    sync_fifo #(
        .W  (ENT_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .flush_i    (clr),
        .push_i     (fifo_push),
        .push_dat_i (push_dat_q),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    // Accumulate; the final sample of a window is folded straight into the average.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        latest_d   = latest_q;
        push_vld_d = 1'b0;
        push_dat_d = push_dat_q;
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
        end else if (take) begin
            if (cnt_q[smp_ch] != '1) begin
                acc_d[smp_ch] = sum;
                cnt_d[smp_ch] = cnt_q[smp_ch] + AVG_SHIFT'(1);
            end else begin
                latest_d[smp_ch] = sum[ACC_W-1:AVG_SHIFT];
                push_vld_d       = 1'b1;
                push_dat_d       = {smp_ch, sum[ACC_W-1:AVG_SHIFT]};
                acc_d[smp_ch]    = '0;
                cnt_d[smp_ch]    = '0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avl_address)
            ADDR_CTRL: rd_mux[1:0] = ctrl_q;
            ADDR_STATUS: begin
                rd_mux[STATUS_EMPTY]                     = fifo_empty;
                rd_mux[STATUS_FULL]                      = fifo_full;
                rd_mux[STATUS_OVF]                       = ovf_q;
                rd_mux[STATUS_LEVEL_LSB +: FIFO_AW+1]    = fifo_level;
            end
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    rd_mux[DATA_VALID]  = 1'b1;
                    rd_mux[ENT_W-1:0]   = fifo_head;
                end
            end
            ADDR_THRESH: rd_mux[FIFO_AW:0] = thresh_q;
            ADDR_LATEST0, ADDR_LATEST1, ADDR_LATEST2, ADDR_LATEST3:
                rd_mux[DATA_W-1:0] = latest_q[avl_address[1:0]];
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        ctrl_d   = wr_ctrl   ? avl_writedata[1:0]       : ctrl_q;
        thresh_d = wr_thresh ? avl_writedata[FIFO_AW:0] : thresh_q;
        ovf_d    = ovf_q;
        if (clr)
            ovf_d = 1'b0;
        else if (fifo_push && fifo_full && !pop)
            ovf_d = 1'b1;
        rdata_d = avl_read ? rd_mux : rdata_q;
        irq_d   = ctrl_q[CTRL_IRQ_EN] && (thresh_q != '0) && (fifo_level >= thresh_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ctrl_q     <= '0;
            thresh_q   <= '0;
            ovf_q      <= 1'b0;
            push_vld_q <= 1'b0;
            push_dat_q <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i]    <= '0;
                cnt_q[i]    <= '0;
                latest_q[i] <= '0;
            end
        end else begin
            ctrl_q     <= ctrl_d;
            thresh_q   <= thresh_d;
            ovf_q      <= ovf_d;
            push_vld_q <= push_vld_d;
            push_dat_q <= push_dat_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i]    <= acc_d[i];
                cnt_q[i]    <= cnt_d[i];
                latest_q[i] <= latest_d[i];
            end
        end
    end

    assign avl_readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_adc_avg_buf.sv
// Directed bench for adc_avg_buf: averaging, interleave, overflow, full push+pop, irq, clear and async reset.
module tb_adc_avg_buf;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        smp_valid;
    logic [7:0]  smp_data;
    logic [1:0]  smp_ch;
    logic [2:0]  avl_address;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic        avl_read;
    logic [31:0] avl_readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] d;

    adc_avg_buf dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .smp_valid     (smp_valid),
        .smp_data      (smp_data),
        .smp_ch        (smp_ch),
        .avl_address   (avl_address),
        .avl_write     (avl_write),
        .avl_writedata (avl_writedata),
        .avl_read      (avl_read),
        .avl_readdata  (avl_readdata),
        .irq           (irq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic smp(input logic [1:0] ch, input logic [7:0] v);
        smp_valid = 1'b1;
        smp_ch    = ch;
        smp_data  = v;
        @(negedge sys_clk);
        smp_valid = 1'b0;
    endtask

    task automatic avg8(input logic [1:0] ch, input logic [7:0] v);
        repeat (8) smp(ch, v);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        avl_write     = 1'b1;
        avl_address   = a;
        avl_writedata = v;
        @(negedge sys_clk);
        avl_write     = 1'b0;
        avl_writedata = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        avl_read    = 1'b1;
        avl_address = a;
        @(negedge sys_clk);
        avl_read    = 1'b0;
        v = avl_readdata;
    endtask

    initial begin
        sys_rst_n     = 1'b0;
        smp_valid     = 1'b0;
        smp_data      = '0;
        smp_ch        = '0;
        avl_address   = '0;
        avl_write     = 1'b0;
        avl_writedata = '0;
        avl_read      = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        tick(1);

        // Reset state
        check("rst_readdata", avl_readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rd(3'd1, d); check("rst_status", d, 32'h1);
        rd(3'd0, d); check("rst_ctrl", d, 32'h0);
        rd(3'd3, d); check("rst_thresh", d, 32'h0);
        rd(3'd4, d); check("rst_latest0", d, 32'h0);

        // 1. Averaging: ch1 10..80 -> 45
        wr(3'd0, 32'h1);
        for (int k = 1; k <= 8; k++) smp(2'd1, 8'(10 * k));
        tick(2);
        rd(3'd1, d); check("avg_status_lvl1", d, 32'h10);
        rd(3'd2, d); check("avg_data", d, 32'h8000_012D);
        rd(3'd5, d); check("avg_latest1", d, 32'h2D);
        tick(3);
        check("rdata_hold", avl_readdata, 32'h2D);
        rd(3'd1, d); check("avg_status_empty", d, 32'h1);

        // 2. Interleave ch0/ch3 with a partial ch2 window spanning it
        repeat (4) smp(2'd2, 8'd100);
        for (int k = 0; k < 8; k++) begin
            smp(2'd0, 8'hFF);
            smp(2'd3, 8'h01);
        end
        repeat (4) smp(2'd2, 8'd20);
        tick(2);
        rd(3'd2, d); check("ilv_ch0", d, 32'h8000_00FF);
        rd(3'd2, d); check("ilv_ch3", d, 32'h8000_0301);
        rd(3'd2, d); check("ilv_ch2_untouched", d, 32'h8000_023C);

        // 3. Overflow: 17 results, no reads
        for (int k = 1; k <= 17; k++) avg8(2'd0, 8'(k));
        tick(2);
        rd(3'd1, d); check("ovf_status", d, 32'h106);
        for (int k = 1; k <= 16; k++) begin
            rd(3'd2, d); check("ovf_drain", d, 32'h8000_0000 | 32'(k));
        end
        rd(3'd2, d); check("ovf_empty_read", d, 32'h0);
        rd(3'd1, d); check("ovf_sticky", d, 32'h5);
        rd(3'd4, d); check("ovf_latest0", d, 32'h11);
        wr(3'd0, 32'h5);
        rd(3'd1, d); check("ovf_cleared", d, 32'h1);

        // 4. Full FIFO: push lands on the same cycle as a DATA pop
        for (int k = 1; k <= 16; k++) avg8(2'd0, 8'(k));
        tick(2);
        repeat (7) smp(2'd2, 8'h40);
        smp_valid = 1'b1; smp_ch = 2'd2; smp_data = 8'h40;
        @(negedge sys_clk);
        smp_valid   = 1'b0;
        avl_read    = 1'b1;
        avl_address = 3'd2;
        @(negedge sys_clk);
        avl_read = 1'b0;
        check("fpp_data", avl_readdata, 32'h8000_0001);
        rd(3'd1, d); check("fpp_status", d, 32'h102);
        for (int k = 2; k <= 16; k++) begin
            rd(3'd2, d); check("fpp_drain", d, 32'h8000_0000 | 32'(k));
        end
        rd(3'd2, d); check("fpp_last", d, 32'h8000_0240);

        // 5. Interrupt
        wr(3'd3, 32'h4);
        wr(3'd0, 32'h3);
        avg8(2'd3, 8'h11);
        avg8(2'd3, 8'h22);
        avg8(2'd3, 8'h33);
        tick(3);
        check("irq_lvl3", {31'b0, irq}, 32'h0);
        avg8(2'd3, 8'h44);
        tick(3);
        check("irq_lvl4", {31'b0, irq}, 32'h1);
        rd(3'd1, d); check("irq_status", d, 32'h40);
        rd(3'd2, d); check("irq_pop", d, 32'h8000_0311);
        check("irq_lag", {31'b0, irq}, 32'h1);
        tick(1);
        check("irq_fall", {31'b0, irq}, 32'h0);
        wr(3'd3, 32'h0);
        avg8(2'd3, 8'h55);
        avg8(2'd3, 8'h66);
        tick(3);
        check("irq_thresh0", {31'b0, irq}, 32'h0);
        rd(3'd3, d); check("thresh_rb", d, 32'h0);
        wr(3'd0, 32'h5);

        // 6. Clear mid-window with queued entries
        repeat (3) avg8(2'd1, 8'h50);
        repeat (5) smp(2'd1, 8'h10);
        tick(2);
        rd(3'd1, d); check("clr_pre_status", d, 32'h30);
        wr(3'd0, 32'h7);
        rd(3'd1, d); check("clr_status", d, 32'h1);
        rd(3'd0, d); check("clr_selfclear", d, 32'h3);
        rd(3'd5, d); check("clr_latest_kept", d, 32'h50);
        avg8(2'd1, 8'h08);
        tick(2);
        rd(3'd2, d); check("clr_fresh_avg", d, 32'h8000_0108);

        // Asynchronous reset mid-burst
        wr(3'd3, 32'h1);
        avg8(2'd0, 8'h77);
        tick(3);
        check("arst_irq_pre", {31'b0, irq}, 32'h1);
        rd(3'd1, d); check("arst_status_pre", d, 32'h10);
        repeat (3) smp(2'd1, 8'h09);
        smp_valid = 1'b1; smp_ch = 2'd1; smp_data = 8'h09;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_readdata", avl_readdata, 32'h0);
        check("arst_irq", {31'b0, irq}, 32'h0);
        check("arst_level", 32'(dut.fifo_level), 32'h0);
        @(negedge sys_clk);
        smp_valid = 1'b0;
        sys_rst_n = 1'b1;
        tick(1);
        rd(3'd1, d); check("arst_status", d, 32'h1);
        rd(3'd0, d); check("arst_ctrl", d, 32'h0);
        rd(3'd4, d); check("arst_latest0", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_avg_buf.md
Name: adc_avg_buf

Overview:
- Downstream consumer of the PCF8591 ADC read path. Takes 8-bit samples, each tagged with a channel number, from the I2C read sequencer.
- Averages 2^AVG_SHIFT samples per channel and pushes each result into a FIFO.
- Exposes the FIFO, status, latest per-channel averages and a level interrupt on an Avalon-MM slave. Nios II software drains conversions in bursts instead of polling every I2C transaction.

Parameters:
- DATA_W, 8, sample and average width
- AVG_SHIFT, 3, log2 of samples averaged per result (1..6)
- FIFO_AW, 4, log2 of FIFO depth (depth 16)

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- smp_valid  in  1  one-cycle strobe, sample present
- smp_data  in  DATA_W  ADC sample
- smp_ch  in  2  channel of sample (PCF8591 AIN0..3)
- avl_address  in  3  word address
- avl_write  in  1  write request
- avl_writedata  in  32  write data
- avl_read  in  1  read request
- avl_readdata  out  32  read data, fixed read latency 1
- irq  out  1  level interrupt, active-high

Behaviour:
- Reset: all outputs 0; CTRL=0, THRESH=0; FIFO empty; accumulators, counters, latest[] and overflow all 0. Reset is asynchronous, so asserting it mid-operation discards partial averages and FIFO contents immediately.
- Accumulation:
  - Four accumulators, each DATA_W+AVG_SHIFT bits, plus four AVG_SHIFT-bit counters, indexed by smp_ch.
  - Samples are taken only when smp_valid and CTRL.en.
  - If cnt[ch] < 2^AVG_SHIFT-1: acc[ch] += smp_data, cnt[ch]++.
  - Otherwise: avg = (acc[ch]+smp_data)>>AVG_SHIFT (truncate), latest[ch]<=avg, push {ch,avg} to FIFO, acc[ch]<=0, cnt[ch]<=0.
  - Push happens on the cycle after the final sample.
- Enable: when CTRL.en=0, samples are ignored and accumulators hold.
- FIFO (depth 2^FIFO_AW, entry = 2+DATA_W bits, write/read pointers one bit wider than FIFO_AW):
  - Push when full and no same-cycle pop: result dropped, latest[] still updated, STATUS.ovf set sticky.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Pop when empty: returns valid=0, pointers unchanged. A same-cycle push is not forwarded.
- Registers (word address):
  - 0 CTRL RW: [0] en, [1] irq_en. Writing [2]=1 is a self-clearing clear: flushes the FIFO, zeroes acc/cnt, clears ovf; latest[] kept. Clear beats a same-cycle push or pop.
  - 1 STATUS RO: [0] empty, [1] full, [2] ovf, [FIFO_AW+4:4] level. Reading STATUS does not clear ovf.
  - 2 DATA RO: a read pops. Returns [31] valid, [9:8] ch, [7:0] avg.
  - 3 THRESH RW: [FIFO_AW:0] level threshold.
  - 4..7 LATEST0..3 RO: [7:0] latest[n].
  - Unmapped bits read 0. Writes to RO addresses are ignored.
- Read timing: avl_readdata is registered and valid the cycle after avl_read. avl_readdata holds its value when no read is active. The pop takes effect on the read-request cycle, so back-to-back reads return consecutive entries.
- irq (registered) = irq_en && THRESH!=0 && level>=THRESH. It deasserts one cycle after the level falls below THRESH.
- Simultaneous avl_read and avl_write to different addresses is not legal Avalon traffic and is not required to work.

Decomposition:
- Shared package adda_pkg: register address localparams (ADDR_CTRL..ADDR_LATEST3), CTRL/STATUS bit indices, default AVG_SHIFT/FIFO_AW.
- One sub-module, sync_fifo, holding the parameterised width/depth FIFO with full/empty/level outputs and a synchronous flush input.
- Accumulators and register file stay in adc_avg_buf.

Test Plan:
1. Averaging: en=1, 8 samples of ch1 = 10,20,...,80 -> one FIFO entry, DATA read = 0x8000_012D (ch1, avg 45); LATEST1=0x2D; STATUS.empty=1 afterwards.
2. Interleaving: alternate ch0=0xFF and ch3=0x01, 16 samples total -> entries {0,0xFF} then {3,0x01} in push order; acc of other channels untouched.
3. Overflow: 17 averages pushed with no reads -> STATUS full=1, ovf=1, level=16; 16 DATA reads return the first 16 results in order, 17th read returns 0x0000_0000.
4. Full push+pop: FIFO full, final sample lands on the same cycle as a DATA read -> level stays 16, ovf remains 0.
5. Interrupt: irq_en=1, THRESH=4 -> irq rises after the 4th push; one DATA read -> irq low within 1 cycle of the level dropping to 3; THRESH=0 -> irq never asserts.
6. Clear and reset: 5 samples accumulated plus 3 entries, then write CTRL=0x7 -> empty, ovf=0, next 8 samples form a fresh average. Asserting sys_rst_n low mid-burst zeroes avl_readdata, irq and level asynchronously.
